// File: rtl/sync_updown_counter.sv
// sync_updown_counter
//
// Parametrised synchronous up/down counter with count enable, synchronous
// parallel load (clamped to the count range), a combinational terminal-count
// output for cascading, a registered one-cycle wrap pulse and a sticky
// overflow flag.
//
// Build option:
//   SYNC_UPDOWN_COUNTER_SAT_EN  - when defined, a step past either end of the
//                                 range holds the count at that end (saturating
//                                 mode). The blocked step still pulses wrap and
//                                 sets ovf. When undefined the count wraps.
//
// Parameters:
//   WIDTH    counter width in bits (>= 1)
//   MODULUS  count range is 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset (q, wrap, ovf -> 0)
//   en       count enable
//   up_dn    direction, 1 = up, 0 = down
//   load     synchronous parallel load, takes priority over en
//   d        load value (values above MODULUS-1 clamp to MODULUS-1)
//   clr_ovf  clears the sticky overflow flag; a same-edge crossing wins
//   q        registered count value
//   tc       combinational terminal count: en & (at top when up / at 0 when down)
//   wrap     registered pulse, high for the cycle after a boundary crossing
//   ovf      registered sticky boundary-crossing flag

module sync_updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // MODULUS-1 always fits in WIDTH bits, even when MODULUS == 2**WIDTH, so
  // every compare below is done against this constant rather than MODULUS.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             wrap_reg, wrap_next;
  logic             ovf_reg, ovf_next;
  logic             at_max, at_zero;
  logic             crossing;

  assign at_max  = (q_reg == MAX_VAL);
  assign at_zero = (q_reg == '0);

  // Terminal count looks only at en/up_dn/q, so it stays asserted during a load.
  assign tc = en & (up_dn ? at_max : at_zero);

  always_comb begin
    q_next    = q_reg;
    crossing  = 1'b0;

    if (load) begin
      q_next = (d > MAX_VAL) ? MAX_VAL : d;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          crossing = 1'b1;
`ifdef SYNC_UPDOWN_COUNTER_SAT_EN
          q_next   = MAX_VAL;
`else
          q_next   = '0;
`endif
        end else begin
          // Not at the top, so the increment cannot leave the range.
          q_next = q_reg + 1'b1;
        end
      end else begin
        if (at_zero) begin
          crossing = 1'b1;
`ifdef SYNC_UPDOWN_COUNTER_SAT_EN
          q_next   = '0;
`else
          q_next   = MAX_VAL;
`endif
        end else begin
          q_next = q_reg - 1'b1;
        end
      end
    end

    // wrap only ever reflects the step just taken; load and hold clear it.
    wrap_next = crossing;
    // A crossing at the same edge as clr_ovf leaves the flag set.
    ovf_next  = crossing | (ovf_reg & ~clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg    <= '0;
      wrap_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
      ovf_reg  <= ovf_next;
    end
  end

  assign q    = q_reg;
  assign wrap = wrap_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Testbench for sync_updown_counter.
// Two instances share one set of inputs: dut_a uses default parameters
// (WIDTH=3, MODULUS=8), dut_b uses WIDTH=4, MODULUS=10. Each directed row
// names the instance it checks and lists, for that cycle, the inputs applied
// and the outputs that must be visible (q/wrap/ovf from earlier edges, tc from
// the current inputs). The stimulus process pushes the row's expectation into
// a scoreboard queue; an independent monitor pops and compares each cycle.

module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] d;
  logic       clr_ovf;

  logic [2:0] d_a;
  logic [2:0] q_a;
  logic       tc_a, wrap_a, ovf_a;
  logic [3:0] q_b;
  logic       tc_b, wrap_b, ovf_b;

  assign d_a = d[2:0];

  always #5 clk = ~clk;

  sync_updown_counter dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .d(d_a), .clr_ovf(clr_ovf), .q(q_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .d(d), .clr_ovf(clr_ovf), .q(q_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
  );

  typedef struct {
    string    name;
    bit       sel;   // 0 = dut_a, 1 = dut_b
    bit [3:0] q;
    bit       w;
    bit       o;
    bit       t;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input string field, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s %s actual=%0d required=%0d", name, field, act, req);
    end
  endtask

  // Monitor: sample 2 time units after the falling edge, well away from posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel) begin
          chk(e.name, "q", int'(q_b), int'(e.q));
          chk(e.name, "wrap", int'(wrap_b), int'(e.w));
          chk(e.name, "ovf", int'(ovf_b), int'(e.o));
          chk(e.name, "tc", int'(tc_b), int'(e.t));
          $display("row %s b: q=%0d wrap=%0d ovf=%0d tc=%0d", e.name, q_b, wrap_b, ovf_b, tc_b);
        end else begin
          chk(e.name, "q", int'(q_a), int'(e.q));
          chk(e.name, "wrap", int'(wrap_a), int'(e.w));
          chk(e.name, "ovf", int'(ovf_a), int'(e.o));
          chk(e.name, "tc", int'(tc_a), int'(e.t));
          $display("row %s a: q=%0d wrap=%0d ovf=%0d tc=%0d", e.name, q_a, wrap_a, ovf_a, tc_a);
        end
      end
    end
  end

  // One directed row: drive inputs for this cycle, queue what must be seen.
  task automatic v(input string name, input bit r, input bit e_in, input bit u,
                   input bit ld, input int dv, input bit c, input bit sel,
                   input int eq, input bit ew, input bit eo, input bit et);
    exp_t x;
    @(negedge clk);
    rst_n   = r;
    en      = e_in;
    up_dn   = u;
    load    = ld;
    d       = 4'(dv);
    clr_ovf = c;
    x.name = name; x.sel = sel; x.q = 4'(eq); x.w = ew; x.o = eo; x.t = et;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    repeat (2) begin
      @(negedge clk);
      rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; d = 4'd0; clr_ovf = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int qi;
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; d = 4'd0; clr_ovf = 1'b0;

    // ---------------- dut_a: default parameters ----------------
    do_reset();
    v("a_rst", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SYNC_UPDOWN_COUNTER_SAT_EN
    for (int i = 0; i < 10; i++) begin
      qi = (i > 7) ? 7 : i;
      v($sformatf("a_sat_up%0d", i), 1, 1, 1, 0, 0, 0, 0, qi, i >= 8, i >= 8, qi == 7);
    end
    v("a_sat_dn0", 1, 1, 0, 0, 0, 0, 0, 7, 1, 1, 0);
    v("a_sat_dn1", 1, 1, 0, 0, 0, 0, 0, 6, 0, 1, 0);
    v("a_sat_rst", 0, 1, 0, 0, 0, 0, 0, 5, 0, 1, 0);
    v("a_sat_rel", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    v("a_sat_res", 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
`else
    for (int i = 0; i < 15; i++) begin
      qi = i % 8;
      // the row at q=6 also asserts reset for one edge
      v($sformatf("a_up%0d", i), (i == 14) ? 1'b0 : 1'b1, 1, 1, 0, 0, 0, 0,
        qi, i == 8, i >= 8, qi == 7);
    end
    v("a_after_rst", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    v("a_resume1",   1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    v("a_resume2",   1, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0);
`endif

    // ---------------- dut_b: WIDTH=4, MODULUS=10 ----------------
    do_reset();
`ifdef SYNC_UPDOWN_COUNTER_SAT_EN
    v("b_sat_dn0",  1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 1);
    v("b_sat_dn1",  1, 1, 0, 0, 0,  0, 1, 0, 1, 1, 1);
    v("b_sat_clr",  1, 0, 0, 0, 0,  1, 1, 0, 1, 1, 0);
    v("b_sat_both", 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 1);
    v("b_sat_ld5",  1, 0, 1, 1, 5,  0, 1, 0, 1, 1, 0);
    v("b_sat_ld13", 1, 1, 1, 1, 13, 0, 1, 5, 0, 1, 0);
    v("b_sat_top",  1, 1, 1, 0, 0,  0, 1, 9, 0, 1, 1);
    v("b_sat_blk",  1, 0, 1, 0, 0,  0, 1, 9, 1, 1, 0);
    v("b_sat_hold", 1, 0, 1, 0, 0,  0, 1, 9, 0, 1, 0);
`else
    for (int i = 0; i < 12; i++) begin
      qi = (10 - (i % 10)) % 10;
      v($sformatf("b_dn%0d", i), 1, 1, 0, 0, 0, 0, 1, qi, (i == 1) || (i == 11), i >= 1, qi == 0);
    end
    v("b_clr",      1, 0, 0, 0, 0,  1, 1, 8, 0, 1, 0);
    v("b_ld5",      1, 0, 0, 1, 5,  0, 1, 8, 0, 0, 0);
    v("b_ld13_en",  1, 1, 1, 1, 13, 0, 1, 5, 0, 0, 0);
    v("b_setwins",  1, 1, 1, 0, 0,  1, 1, 9, 0, 0, 1);
    v("b_crossed",  1, 0, 1, 0, 0,  0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      v($sformatf("b_hold%0d", i), 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    v("b_ld_tc",    1, 1, 0, 1, 3,  0, 1, 0, 0, 1, 1);
    v("b_ld3",      1, 0, 0, 0, 0,  0, 1, 3, 0, 1, 0);
`endif

    // let the monitor drain the queue, bounded
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    #4;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_updown_counter.md
# sync_updown_counter

Parametrised synchronous up/down counter that generalises the team's 3-bit free-running up counter. Adds configurable width and modulus, count enable, direction control, synchronous parallel load, a cascade terminal-count output, and registered wrap and overflow flags. With default parameters and `en=1`, `up_dn=1`, `load=0`, it counts 0→7→0 exactly like the 3-bit counter. It is intended as the counting primitive for timers, dividers and cascaded prescalers.

## Interface
- `WIDTH`, default 3: counter width in bits; must be ≥ 1.
- `MODULUS`, default 8: count range is 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2^WIDTH.
- `clk`, input, 1: rising-edge clock. One clock domain only.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `en`, input, 1: count enable.
- `up_dn`, input, 1: direction; 1 = up, 0 = down.
- `load`, input, 1: synchronous parallel load.
- `d`, input, WIDTH: load value.
- `clr_ovf`, input, 1: clears the sticky overflow flag.
- `q`, output, WIDTH: count value (registered).
- `tc`, output, 1: combinational terminal count, for cascading.
- `wrap`, output, 1: registered one-cycle pulse on a boundary crossing.
- `ovf`, output, 1: sticky boundary-crossing flag (registered).

## Operation
- Priority at each rising edge of `clk`: `rst_n`=0, then `load`, then `en`, then hold.
- Reset (`rst_n`=0 at an edge):
  - `q`=0, `wrap`=0, `ovf`=0.
  - Reset overrides any operation in progress. There is no partial state; the count restarts from 0.
- Load:
  - `q` ← `d` if `d` ≤ MODULUS-1; otherwise `q` ← MODULUS-1 (clamped).
  - `wrap`=0 in the next cycle.
  - `ovf` is not modified by a load.
- Count (`en`=1, `load`=0):
  - Up: `q` ← `q`+1. If `q`=MODULUS-1, `q` ← 0 and the step is a boundary crossing.
  - Down: `q` ← `q`-1. If `q`=0, `q` ← MODULUS-1 and the step is a boundary crossing.
- Hold (`en`=0, `load`=0): `q` is unchanged and `wrap`=0.
- `tc` = `en` & (`up_dn` ? `q`==MODULUS-1 : `q`==0). It is purely combinational and asserted even when `load`=1. The next stage counts when `tc`=1.
- `wrap` is 1 for exactly the cycle following the edge at which a boundary crossing occurs.
- `ovf`:
  - Set by a boundary crossing.
  - `clr_ovf`=1 clears it at the edge.
  - If a crossing and `clr_ovf` occur at the same edge, set wins and `ovf`=1.
- `up_dn` may change on any cycle. The new direction applies at the same edge with no dead cycle.
- Arithmetic is WIDTH bits, modulo MODULUS. Intermediate compares must not overflow when MODULUS=2^WIDTH.

## Timing
- `q`, `wrap` and `ovf` update only on the rising edge of `clk`, with 1-cycle latency from `en`, `load`, `d` and `clr_ovf`.
- `tc` has 0-cycle latency; it is combinational from `en`, `up_dn` and `q`.
- Reset takes effect at the first edge with `rst_n`=0. All outputs hold their reset values until the first edge with `rst_n`=1.
- Full-rate counting: one step per enabled cycle, with no bubbles.

## Configuration
- Macro: `SYNC_UPDOWN_COUNTER_SAT_EN`.
- Not defined (default): wrap mode, as described above.
- Defined: saturating mode.
  - An up step at MODULUS-1 holds `q`=MODULUS-1.
  - A down step at 0 holds `q`=0.
  - Each such blocked step is treated as a boundary crossing: `wrap` pulses and `ovf` sets.
  - `tc` is unchanged.
  - Load, reset and priority are unchanged.

## Test plan
- Defaults, `en`=1, `up_dn`=1, 10 cycles after reset release:
  - `q` = 0,1,…,7,0,1.
  - `wrap`=1 only in the cycle where `q`=0 after 7.
  - `tc`=1 only while `q`=7.
- WIDTH=4, MODULUS=10, down count from reset:
  - `q` = 0,9,8,…,0,9.
  - `ovf`=1 after the first crossing and stays set until `clr_ovf`=1.
  - Crossing and `clr_ovf` at the same edge → `ovf`=1.
- Load with WIDTH=4, MODULUS=10:
  - `load`=1, `d`=5 → `q`=5.
  - `d`=13 → `q`=9 (clamped).
  - `load`=1 together with `en`=1 → the load wins.
  - `en`=0 for 3 cycles → `q` holds.
- Reset mid-count: `rst_n`=0 for one edge at `q`=6 with `ovf`=1 → `q`=0, `ovf`=0, `wrap`=0 next cycle; counting resumes 1,2,… after release.
- `SYNC_UPDOWN_COUNTER_SAT_EN` defined, defaults, up for 10 cycles:
  - `q` sticks at 7.
  - `wrap` pulses on each blocked step.
  - Switch to `up_dn`=0 → `q` = 6,5,… with no dead cycle.
